// File: rtl/video_chk_pkg.sv
// Shared types and defaults for the per-channel video SPI checker.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package video_chk_pkg;

  // Checker sequence: chip-select setup, bit shifting, hold, then compare.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    CHECK = 3'd4
  } state_t;

  localparam int DEF_WIDTH      = 12;
  localparam int DEF_CLK_DIV    = 4;
  localparam int DEF_TOLERANCE  = 8;
  localparam int DEF_FAIL_LIMIT = 3;
  localparam int NUM_CH         = 10;

  localparam logic [15:0] ERR_MAX    = 16'hFFFF;
  localparam logic [7:0]  STREAK_MAX = 8'hFF;

endpackage

// File: rtl/spi_rx_engine.sv
// SPI mode-3 receive datapath: SCK divider, SCK/CS generation, MSB-first shift register.
// Latency: setup, WIDTH bits and hold each last CLK_DIV sys_clk cycles per SCK half-period.
// Backpressure: none; phase strobes from the parent FSM steer it, the slave cannot stall it.
module spi_rx_engine
  import video_chk_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             in_setup,
  input  logic             in_shift,
  input  logic             in_hold,
  input  logic             sdatav,
  output logic             sckv,
  output logic             slv,
  output logic             phase_end,
  output logic             shift_done,
  output logic             done,
  output logic [WIDTH-1:0] rx_word
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(WIDTH);

  logic [DW-1:0]    div_q, div_d;
  logic             half_q, half_d;     // 0: SCK low half of a bit, 1: SCK high half
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             active;
  logic             div_end;

  assign active     = in_setup | in_shift | in_hold;
  assign div_end    = (div_q == DW'(CLK_DIV - 1));
  assign phase_end  = div_end;
  assign shift_done = in_shift & div_end & half_q & (bit_q == BW'(WIDTH - 1));
  assign done       = in_hold & div_end;
  // SCK only drops during the low half of a bit; CS covers setup through hold.
  assign sckv       = ~(in_shift & ~half_q);
  assign slv        = ~active;
  assign rx_word    = shreg_q;

  // Divider, half-period/bit tracking and sampling on the SCK rising edge.
  always_comb begin
    div_d   = div_q;
    half_d  = half_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    if (!active || div_end) begin
      div_d = '0;
    end else begin
      div_d = div_q + 1'b1;
    end
    if (!in_shift) begin
      half_d = 1'b0;
      bit_d  = '0;
    end else if (div_end) begin
      half_d = ~half_q;
      if (!half_q) begin
        // SCK goes 0->1 on this edge: slave data has been stable since the falling edge.
        shreg_d = {shreg_q[WIDTH-2:0], sdatav};
      end else begin
        bit_d = bit_q + 1'b1;
      end
    end
  end

  // Datapath registers; reset returns the divider and shifter to their idle values.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      half_q  <= 1'b0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      div_q   <= div_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: rtl/video_spi_checker.sv
// Per-channel BOS video word checker: reads one word over SPI, compares within tolerance, drives LEDs.
// Latency: start sampled at edge 0 gives rx_valid in cycle 1 + CLK_DIV*(2*WIDTH+2).
// Backpressure: start is ignored while busy, including the CHECK cycle.
module video_spi_checker
  import video_chk_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int TOLERANCE  = DEF_TOLERANCE,
  parameter int FAIL_LIMIT = DEF_FAIL_LIMIT
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] exp_data,
  input  logic             clr,
  input  logic             sdatav,
  output logic             sckv,
  output logic             slv,
  output logic             busy,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             match,
  output logic [15:0]      err_count,
  output logic             led_green,
  output logic             led_red
);

  localparam logic [WIDTH:0] TOL_V   = (WIDTH + 1)'(TOLERANCE);
  localparam logic [7:0]     LIMIT_V = 8'(FAIL_LIMIT);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             match_q, match_d;
  logic [15:0]      err_cnt_q, err_cnt_d;
  logic [7:0]       streak_q, streak_d;
  logic             red_q, red_d;
  logic             green_q, green_d;

  logic             phase_end, shift_done, hold_done;
  logic [WIDTH-1:0] rx_word;
  logic [WIDTH:0]   diff, abs_diff;
  logic             cmp_ok;

  spi_rx_engine #(
    .WIDTH   (WIDTH),
    .CLK_DIV (CLK_DIV)
  ) u_rx (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .in_setup   (state_q == SETUP),
    .in_shift   (state_q == SHIFT),
    .in_hold    (state_q == HOLD),
    .sdatav     (sdatav),
    .sckv       (sckv),
    .slv        (slv),
    .phase_end  (phase_end),
    .shift_done (shift_done),
    .done       (hold_done),
    .rx_word    (rx_word)
  );

  assign busy      = (state_q != IDLE);
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign match     = match_q;
  assign err_count = err_cnt_q;
  assign led_green = green_q;
  assign led_red   = red_q;

  // Unsigned distance computed one bit wider so rx=0 vs exp=max cannot wrap into a match.
  always_comb begin
    diff     = {1'b0, rx_word} - {1'b0, exp_q};
    abs_diff = diff[WIDTH] ? (~diff + 1'b1) : diff;
    cmp_ok   = (abs_diff <= TOL_V);
  end

  // Next-state sequencing; the engine reports when each timed phase ends.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)      state_d = SETUP;
      SETUP:   if (phase_end)  state_d = SHIFT;
      SHIFT:   if (shift_done) state_d = HOLD;
      HOLD:    if (hold_done)  state_d = CHECK;
      CHECK:                   state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Result, counters and LEDs; clr overrides the counter update but not the result.
  always_comb begin
    exp_d      = exp_q;
    rx_data_d  = rx_data_q;
    match_d    = match_q;
    rx_valid_d = 1'b0;
    err_cnt_d  = err_cnt_q;
    streak_d   = streak_q;
    red_d      = red_q;
    green_d    = green_q;
    if (state_q == IDLE && start) begin
      exp_d = exp_data;
    end
    if (state_q == CHECK) begin
      rx_data_d  = rx_word;
      match_d    = cmp_ok;
      rx_valid_d = 1'b1;
      if (cmp_ok) begin
        streak_d = 8'd0;
      end else begin
        if (err_cnt_q != ERR_MAX)   err_cnt_d = err_cnt_q + 16'd1;
        if (streak_q != STREAK_MAX) streak_d  = streak_q + 8'd1;
        if (streak_d >= LIMIT_V)    red_d     = 1'b1;
      end
    end
    if (clr) begin
      err_cnt_d = 16'd0;
      streak_d  = 8'd0;
      red_d     = 1'b0;
    end
    // Green follows the latest compare only, and never lights alongside red.
    if (state_q == CHECK) begin
      green_d = cmp_ok & ~red_d;
    end
  end

  // State register.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Result and status registers.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      exp_q      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      match_q    <= 1'b0;
      err_cnt_q  <= 16'd0;
      streak_q   <= 8'd0;
      red_q      <= 1'b0;
      green_q    <= 1'b0;
    end else begin
      exp_q      <= exp_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      match_q    <= match_d;
      err_cnt_q  <= err_cnt_d;
      streak_q   <= streak_d;
      red_q      <= red_d;
      green_q    <= green_d;
    end
  end

endmodule

// File: tb/tb_video_spi_checker.sv
// Bench for video_spi_checker: SPI slave BFM, cycle-level behavioural model, directed transactions.
// Latency: model predicts every output on every cycle from the start edge number.
// Backpressure: exercises start while busy and start during the compare cycle.
`timescale 1ns/1ps
module tb_video_spi_checker;

  localparam int W   = 12;
  localparam int CD  = 4;
  localparam int TOL = 8;
  localparam int LIM = 3;
  localparam int LAT = 1 + CD * (2 * W + 2);

  logic         sys_clk  = 1'b0;
  logic         rst      = 1'b1;
  logic         start    = 1'b0;
  logic [W-1:0] exp_data = '0;
  logic         clr      = 1'b0;
  logic         sdatav   = 1'b0;
  logic         sckv, slv, busy, rx_valid, match, led_green, led_red;
  logic [W-1:0] rx_data;
  logic [15:0]  err_count;

  int checks   = 0;
  int failures = 0;

  video_spi_checker #(
    .WIDTH(W), .CLK_DIV(CD), .TOLERANCE(TOL), .FAIL_LIMIT(LIM)
  ) dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .start     (start),
    .exp_data  (exp_data),
    .clr       (clr),
    .sdatav    (sdatav),
    .sckv      (sckv),
    .slv       (slv),
    .busy      (busy),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .match     (match),
    .err_count (err_count),
    .led_green (led_green),
    .led_red   (led_red)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=0x%0h want=0x%0h t=%0t", nm, got, want, $time);
    end
  endtask

  // SPI slave: MSB first, next bit presented on each SCK falling edge.
  logic [W-1:0] bfm_word = '0;
  int nr = 0;
  int rise_cnt = 0;
  always @(posedge sckv or posedge slv) begin
    if (slv) nr = 0;
    else begin
      nr++;
      rise_cnt++;
    end
  end
  always @(negedge sckv) begin
    if (!slv) sdatav = (nr < W) ? bfm_word[W-1-nr] : 1'b0;
  end

  // Behavioural model: timing from the accepting edge number, results from plain arithmetic.
  bit           frc = 1'b0;
  int           n = 0, s = 0;
  bit           act = 1'b0;
  logic [W-1:0] mw = '0, me = '0, m_rx = '0;
  bit           m_match = 0, m_red = 0, m_green = 0;
  logic [15:0]  m_err = '0;
  int           m_streak = 0;

  function automatic bit within_tol(input logic [W-1:0] a, input logic [W-1:0] b);
    int d;
    d = int'(a) - int'(b);
    if (d < 0) d = -d;
    return d <= TOL;
  endfunction

  always @(posedge sys_clk) begin
    bit ok, e_rv, e_bz, e_sl, e_sk, res;
    #1;
    n++;
    res = 1'b0;
    ok  = 1'b0;
    if (rst) begin
      act = 0; m_rx = '0; m_match = 0; m_err = '0; m_streak = 0; m_red = 0; m_green = 0;
    end else begin
      if (act && n == s + LAT) begin
        res = 1'b1;
        ok = within_tol(mw, me);
        m_rx = mw;
        m_match = ok;
        if (ok) m_streak = 0;
        else begin
          if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
          if (m_streak < 255) m_streak++;
          if (m_streak >= LIM) m_red = 1;
        end
      end
      if (clr) begin
        m_err = '0; m_streak = 0; m_red = 0;
      end
      if (res) m_green = ok && !m_red;
      if (frc) m_err = 16'hFFFE;
      if (start && (!act || n > s + LAT)) begin
        act = 1; s = n; mw = bfm_word; me = exp_data;
      end
    end
    e_rv = act && (n == s + LAT);
    e_bz = act && (n < s + LAT);
    e_sl = !(act && (n < s + LAT - 1));
    e_sk = !(act && n >= s + CD && n < s + CD + 2 * W * CD && (((n - s - CD) / CD) % 2) == 0);
    chk("cyc_rx_valid", 32'(rx_valid), 32'(e_rv));
    chk("cyc_busy", 32'(busy), 32'(e_bz));
    chk("cyc_slv", 32'(slv), 32'(e_sl));
    chk("cyc_sckv", 32'(sckv), 32'(e_sk));
    chk("cyc_rx_data", 32'(rx_data), 32'(m_rx));
    chk("cyc_match", 32'(match), 32'(m_match));
    chk("cyc_err_count", 32'(err_count), 32'(m_err));
    chk("cyc_led_red", 32'(led_red), 32'(m_red));
    chk("cyc_led_green", 32'(led_green), 32'(m_green));
    chk("cyc_leds_excl", 32'(led_green & led_red), 32'd0);
  end

  // One transaction; reports start-to-rx_valid latency and SCK rising edges while selected.
  task automatic run_txn(input logic [W-1:0] word, input logic [W-1:0] expv, input bit spam,
                         input int clr_cyc, output int lat, output int rises);
    int r0;
    bit got;
    @(negedge sys_clk);
    bfm_word = word;
    exp_data = expv;
    start = 1'b1;
    r0 = rise_cnt;
    @(posedge sys_clk);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 400) begin
      @(negedge sys_clk);
      start = spam && (((lat % 20) == 10) || (lat == LAT - 1));
      clr = (lat == clr_cyc);
      if (spam && lat == 30) exp_data = ~expv;
      @(posedge sys_clk);
      lat++;
      #1;
      got = rx_valid;
    end
    @(negedge sys_clk);
    start = 1'b0;
    clr = 1'b0;
    rises = rise_cnt - r0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL txn_timeout got=no_rx_valid want=rx_valid within 400 cycles");
    end
  endtask

  task automatic pulse_clr();
    @(negedge sys_clk);
    clr = 1'b1;
    @(negedge sys_clk);
    clr = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, rises, extra;
    repeat (3) @(negedge sys_clk);
    chk("rst_sckv", 32'(sckv), 32'd1);
    chk("rst_slv", 32'(slv), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_green", 32'(led_green), 32'd0);
    chk("rst_red", 32'(led_red), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    run_txn(12'h5A3, 12'h5A3, 1'b0, -1, lat, rises);
    chk("t1_latency", 32'(lat), 32'd105);
    chk("t1_sck_rises", 32'(rises), 32'd12);
    chk("t1_rx_data", 32'(rx_data), 32'h5A3);
    chk("t1_match", 32'(match), 32'd1);
    chk("t1_green", 32'(led_green), 32'd1);
    chk("t1_err", 32'(err_count), 32'd0);

    run_txn(12'd108, 12'd100, 1'b0, -1, lat, rises);
    chk("tol_edge_match", 32'(match), 32'd1);
    run_txn(12'd109, 12'd100, 1'b0, -1, lat, rises);
    chk("tol_over_match", 32'(match), 32'd0);
    chk("tol_over_err", 32'(err_count), 32'd1);
    chk("tol_over_green", 32'(led_green), 32'd0);
    chk("tol_over_red", 32'(led_red), 32'd0);

    pulse_clr();
    @(negedge sys_clk);
    chk("clr_err", 32'(err_count), 32'd0);
    run_txn(12'h200, 12'h100, 1'b0, -1, lat, rises);
    chk("streak1_red", 32'(led_red), 32'd0);
    run_txn(12'h000, 12'h032, 1'b0, -1, lat, rises);
    chk("streak2_red", 32'(led_red), 32'd0);
    run_txn(12'hFFF, 12'hFF0, 1'b0, -1, lat, rises);
    chk("streak3_red", 32'(led_red), 32'd1);
    chk("streak3_err", 32'(err_count), 32'd3);
    run_txn(12'h7F8, 12'h7F0, 1'b0, -1, lat, rises);
    chk("sticky_match", 32'(match), 32'd1);
    chk("sticky_green", 32'(led_green), 32'd0);
    chk("sticky_red", 32'(led_red), 32'd1);
    pulse_clr();
    run_txn(12'h123, 12'h123, 1'b0, -1, lat, rises);
    chk("cleared_red", 32'(led_red), 32'd0);
    chk("cleared_green", 32'(led_green), 32'd1);
    chk("cleared_err", 32'(err_count), 32'd0);

    run_txn(12'h3C3, 12'h3C3, 1'b1, -1, lat, rises);
    chk("spam_latency", 32'(lat), 32'd105);
    chk("spam_match", 32'(match), 32'd1);
    extra = 0;
    repeat (150) begin
      @(posedge sys_clk);
      #1;
      if (rx_valid || busy) extra++;
    end
    chk("spam_single_txn", 32'(extra), 32'd0);

    @(negedge sys_clk);
    bfm_word = 12'h6E1;
    exp_data = 12'h6E1;
    start = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    start = 1'b0;
    repeat (46) @(negedge sys_clk);
    chk("bit5_slv_low", 32'(slv), 32'd0);
    chk("bit5_sck_low", 32'(sckv), 32'd0);
    rst = 1'b1;
    #1;
    chk("arst_sckv", 32'(sckv), 32'd1);
    chk("arst_slv", 32'(slv), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_rx_data", 32'(rx_data), 32'd0);
    chk("arst_match", 32'(match), 32'd0);
    chk("arst_green", 32'(led_green), 32'd0);
    @(posedge sys_clk);
    @(negedge sys_clk);
    rst = 1'b0;
    run_txn(12'hABC, 12'hAB4, 1'b0, -1, lat, rises);
    chk("post_rst_latency", 32'(lat), 32'd105);
    chk("post_rst_rises", 32'(rises), 32'd12);
    chk("post_rst_rx_data", 32'(rx_data), 32'hABC);
    chk("post_rst_match", 32'(match), 32'd1);

    run_txn(12'h200, 12'h100, 1'b0, LAT - 1, lat, rises);
    chk("clr_check_match", 32'(match), 32'd0);
    chk("clr_check_rx", 32'(rx_data), 32'h200);
    chk("clr_check_err", 32'(err_count), 32'd0);
    chk("clr_check_red", 32'(led_red), 32'd0);

    @(negedge sys_clk);
    force dut.err_cnt_d = 16'hFFFE;
    frc = 1'b1;
    @(negedge sys_clk);
    release dut.err_cnt_d;
    frc = 1'b0;
    @(negedge sys_clk);
    chk("preload_err", 32'(err_count), 32'hFFFE);
    run_txn(12'h000, 12'hFFF, 1'b0, -1, lat, rises);
    chk("nowrap_match", 32'(match), 32'd0);
    chk("sat1_err", 32'(err_count), 32'hFFFF);
    run_txn(12'hFFF, 12'h000, 1'b0, -1, lat, rises);
    chk("sat2_match", 32'(match), 32'd0);
    chk("sat2_err", 32'(err_count), 32'hFFFF);

    repeat (3) @(negedge sys_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_spi_checker.md
Name: video_spi_checker

Overview:
- Per-channel consumer of the BOS video SPI port (sdatav/sckv/slv); one instance per channel, 10 at top level.
- On each start pulse (issued after a DAC update has settled), reads one WIDTH-bit video word as SPI master, mode 3, MSB first.
- Compares the word against the expected code within a tolerance window.
- Drives that channel's rm_green / rm_red LED pair; keeps a saturating error count.

Parameters:
- WIDTH, 12, video word length in bits.
- CLK_DIV, 4, sys_clk cycles per SCK half-period; must be >= 2.
- TOLERANCE, 8, max allowed |rx - expected|, unsigned.
- FAIL_LIMIT, 3, consecutive mismatches needed to set the red latch; range 1..255.

Ports:
- sys_clk  in  1  system clock, 16 MHz PLL c0.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle transaction request; ignored while busy.
- exp_data  in  WIDTH  expected code; captured on accepted start.
- clr  in  1  clears red latch, error count and fail streak.
- sdatav  in  1  serial data from BOS; top level drives the inout as input only.
- sckv  out  1  SPI clock, idles high.
- slv  out  1  chip select, active-low.
- busy  out  1  transaction in progress.
- rx_data  out  WIDTH  last received word.
- rx_valid  out  1  one-cycle pulse when rx_data and match update.
- match  out  1  result of last compare.
- err_count  out  16  saturating total mismatch count.
- led_green  out  1  channel healthy.
- led_red  out  1  sticky failure indicator.

Behaviour:
- Reset (async, immediate, including mid-transaction): state IDLE, sckv=1, slv=1, busy=0, rx_data=0, rx_valid=0, match=0, err_count=0, led_green=0, led_red=0, fail streak=0, divider=0.
- FSM states:
  - IDLE: start=1 → SETUP. Capture exp_data. busy=1 from next cycle.
  - SETUP: slv=0, sckv=1 for CLK_DIV cycles → SHIFT.
  - SHIFT: per bit, sckv=0 for CLK_DIV cycles, then sckv=1 for CLK_DIV cycles. sdatav is shifted into the LSB on the sys_clk edge where sckv goes 0→1 (slave changes data on the falling edge). After WIDTH bits → HOLD.
  - HOLD: sckv=1, slv=0 for CLK_DIV cycles → CHECK.
  - CHECK: one cycle. slv=1, rx_data and match registered, rx_valid=1, counters updated → IDLE, busy=0.
- Latency: start sampled at edge 0 gives rx_valid high in cycle 1 + CLK_DIV*(2*WIDTH+2). Defaults: cycle 105.
- start in the same cycle as CHECK is ignored. Next accepted start is earliest one cycle after returning to IDLE.
- Compare: diff = {1'b0,rx} - {1'b0,exp} in WIDTH+1-bit two's complement. abs taken; match = (abs <= TOLERANCE). Boundaries: rx=0,exp=4095 gives abs 4095; exact equality always matches.
- On match: fail streak=0, led_green=1 unless led_red.
- On mismatch:
  - err_count increments, saturating at 16'hFFFF.
  - fail streak increments, saturating at 255.
  - led_green=0.
  - When streak reaches FAIL_LIMIT, led_red=1 (sticky).
- led_green = last result matched AND led_red=0. Never both LEDs high.
- clr: takes effect at next edge, in any state.
  - Zeros led_red, err_count and fail streak. led_green is not changed.
  - Does not abort a transaction.
  - If clr and a CHECK mismatch coincide, clr wins for counters, but match and rx_data still update.

Decomposition:
- Shared package/include video_chk_pkg holds:
  - state encoding (IDLE, SETUP, SHIFT, HOLD, CHECK);
  - default WIDTH, CLK_DIV and TOLERANCE constants;
  - NUM_CH=10.
- One natural sub-module: spi_rx_engine, covering the divider, sckv/slv generation and shift register, with a done pulse.
- The checker FSM, compare and LED logic stay in the parent.

Test Plan:
- exp=12'h5A3, BFM returns 12'h5A3 → rx_valid at cycle 105, match=1, led_green=1, err_count=0. Exactly 12 sckv rising edges while slv=0.
- exp=100, rx=108 → match=1. rx=109 → match=0, err_count=1, led_green=0, led_red=0.
- Three consecutive mismatches, FAIL_LIMIT=3 → led_red=1 after the third rx_valid. A following match gives led_green=0, led_red=1. clr then a match → led_red=0, led_green=1, err_count=0.
- start pulsed repeatedly while busy → exactly one transaction; exp_data change mid-transaction has no effect on the compare.
- rst asserted in SHIFT at bit 5 → same cycle: sckv=1, slv=1, busy=0, all outputs 0. Next start runs a full clean transaction.
- Force err_count to 16'hFFFE via 2 more mismatches and beyond → holds 16'hFFFF. Also check rx=0, exp=4095 → match=0 (no wrap).
